// File: rtl/bcd_number_entry_pkg.sv
// Shared types for the BCD operand path: entry FSM states, keypad codes and the
// sign-magnitude two-digit operand used by the entry, ten's-complement and adder stages.
package bcd_number_entry_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } entry_state_t;

    localparam logic [3:0] KEY_NEG_DEF = 4'hA;
    localparam logic [3:0] KEY_CLR_DEF = 4'hB;
    localparam logic [3:0] KEY_BSP_DEF = 4'hC;
    localparam logic [3:0] KEY_ENT_DEF = 4'hD;

    typedef struct packed {
        logic       sign;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_operand_t;

    localparam bcd_operand_t BCD_ZERO = '{sign: 1'b0, tens: 4'd0, ones: 4'd0};

    // A committed zero never carries a sign, so downstream never sees -0.
    function automatic bcd_operand_t bcd_normalise(input bcd_operand_t v);
        bcd_operand_t r;
        r = v;
        if (v.tens == 4'd0 && v.ones == 4'd0)
            r.sign = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/bcd_key_classify.sv
// Decodes a raw keypad code into one-hot key classes; codes outside the map
// (E/F with the default map) assert nothing.
module bcd_key_classify #(
    parameter logic [3:0] KEY_NEG = 4'hA,
    parameter logic [3:0] KEY_CLR = 4'hB,
    parameter logic [3:0] KEY_BSP = 4'hC,
    parameter logic [3:0] KEY_ENT = 4'hD
) (
    input  logic [3:0] key_code,
    output logic       is_digit,
    output logic       is_neg,
    output logic       is_clr,
    output logic       is_bsp,
    output logic       is_ent
);

    always_comb begin
        is_digit = (key_code <= 4'd9);
        is_neg   = (key_code == KEY_NEG);
        is_clr   = (key_code == KEY_CLR);
        is_bsp   = (key_code == KEY_BSP);
        is_ent   = (key_code == KEY_ENT);
    end

endmodule

// File: rtl/bcd_number_entry.sv
// Keypad entry stage: assembles a signed two-digit BCD operand from key strobes
// and hands it downstream over a valid/ready handshake.
module bcd_number_entry
    import bcd_number_entry_pkg::*;
#(
    parameter logic [3:0] KEY_NEG = KEY_NEG_DEF,
    parameter logic [3:0] KEY_CLR = KEY_CLR_DEF,
    parameter logic [3:0] KEY_BSP = KEY_BSP_DEF,
    parameter logic [3:0] KEY_ENT = KEY_ENT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [8:0] out_val,
    output logic [8:0] disp_val,
    output logic [1:0] digit_cnt,
    output logic       entry_err
);

    entry_state_t state;
    bcd_operand_t entry;
    bcd_operand_t committed;

    logic is_digit;
    logic is_neg;
    logic is_clr;
    logic is_bsp;
    logic is_ent;

    bcd_key_classify #(
        .KEY_NEG(KEY_NEG),
        .KEY_CLR(KEY_CLR),
        .KEY_BSP(KEY_BSP),
        .KEY_ENT(KEY_ENT)
    ) u_classify (
        .key_code(key_code),
        .is_digit(is_digit),
        .is_neg  (is_neg),
        .is_clr  (is_clr),
        .is_bsp  (is_bsp),
        .is_ent  (is_ent)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            entry     <= BCD_ZERO;
            committed <= BCD_ZERO;
            digit_cnt <= 2'd0;
            out_valid <= 1'b0;
            entry_err <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid && is_digit) begin
                        entry.ones <= key_code;
                        entry.tens <= 4'd0;
                        digit_cnt  <= 2'd1;
                        state      <= ENTRY;
                    end else if (key_valid && is_neg) begin
                        entry.sign <= 1'b1;
                        state      <= ENTRY;
                    end
                end

                ENTRY: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            if (digit_cnt < 2'd2) begin
                                entry.tens <= entry.ones;
                                entry.ones <= key_code;
                                digit_cnt  <= digit_cnt + 2'd1;
                            end else begin
                                entry_err <= 1'b1;
                            end
                        end else if (is_neg) begin
                            entry.sign <= ~entry.sign;
                        end else if (is_bsp) begin
                            if (digit_cnt != 2'd0) begin
                                entry.ones <= entry.tens;
                                entry.tens <= 4'd0;
                                digit_cnt  <= digit_cnt - 2'd1;
                            end else begin
                                entry.sign <= 1'b0;
                                state      <= IDLE;
                            end
                        end else if (is_clr) begin
                            entry     <= BCD_ZERO;
                            digit_cnt <= 2'd0;
                            state     <= IDLE;
                        end else if (is_ent && digit_cnt != 2'd0) begin
                            committed <= bcd_normalise(entry);
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    // A transfer and an abort both end the hold; a transfer also
                    // swallows any key arriving on the same edge.
                    if (out_ready || (key_valid && is_clr)) begin
                        out_valid <= 1'b0;
                        entry     <= BCD_ZERO;
                        digit_cnt <= 2'd0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_val  = committed;
    assign disp_val = entry;

endmodule

// File: tb/tb_bcd_number_entry.sv
// Directed vector bench for bcd_number_entry: a table of single-cycle steps with
// hand-computed expected outputs, plus asynchronous-reset sequences.
module tb_bcd_number_entry;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       out_ready;
    logic       out_valid;
    logic [8:0] out_val;
    logic [8:0] disp_val;
    logic [1:0] digit_cnt;
    logic       entry_err;

    int checks = 0;
    int errors = 0;

    bcd_number_entry dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_val  (out_val),
        .disp_val (disp_val),
        .digit_cnt(digit_cnt),
        .entry_err(entry_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic       rdy;
        logic       ov;
        logic [8:0] val;
        logic [8:0] disp;
        logic [1:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    localparam logic [3:0] NEG = 4'hA;
    localparam logic [3:0] CLR = 4'hB;
    localparam logic [3:0] BSP = 4'hC;
    localparam logic [3:0] ENT = 4'hD;

    task automatic add(input logic kv, input logic [3:0] kc, input logic rdy,
                       input logic ov, input logic [8:0] val, input logic [8:0] disp,
                       input logic [1:0] cnt, input logic err);
        vec_t v;
        v.kv = kv; v.kc = kc; v.rdy = rdy; v.ov = ov;
        v.val = val; v.disp = disp; v.cnt = cnt; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ov, input logic chk_val,
                             input logic [8:0] val, input logic [8:0] disp,
                             input logic [1:0] cnt, input logic err);
        chk({tag, ".out_valid"}, {8'd0, out_valid}, {8'd0, ov});
        if (chk_val) chk({tag, ".out_val"}, out_val, val);
        chk({tag, ".disp_val"}, disp_val, disp);
        chk({tag, ".digit_cnt"}, {7'd0, digit_cnt}, {7'd0, cnt});
        chk({tag, ".entry_err"}, {8'd0, entry_err}, {8'd0, err});
    endtask

    task automatic step(input logic kv, input logic [3:0] kc, input logic rdy);
        key_valid = kv;
        key_code  = kc;
        out_ready = rdy;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        out_ready = 1'b0;
    endtask

    initial begin
        key_valid = 1'b0;
        key_code  = 4'h0;
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b1, 9'h000, 9'h000, 2'd0, 1'b0);
        rst = 1'b0;

        // 4,7,ENT held five cycles, then accepted
        add(1, 4'h4, 0, 0, 9'h000, 9'h004, 1, 0);
        add(1, 4'h7, 0, 0, 9'h000, 9'h047, 2, 0);
        add(1, ENT,  0, 1, 9'h047, 9'h047, 2, 0);
        for (int i = 0; i < 5; i++) add(0, 4'h0, 0, 1, 9'h047, 9'h047, 2, 0);
        add(0, 4'h0, 1, 0, 9'h000, 9'h000, 0, 0);
        // NEG,2,5,ENT with ready high: valid for exactly one cycle
        add(1, NEG,  1, 0, 9'h000, 9'h100, 0, 0);
        add(1, 4'h2, 1, 0, 9'h000, 9'h102, 1, 0);
        add(1, 4'h5, 1, 0, 9'h000, 9'h125, 2, 0);
        add(1, ENT,  1, 1, 9'h125, 9'h125, 2, 0);
        add(0, 4'h0, 1, 0, 9'h000, 9'h000, 0, 0);
        // NEG,0,ENT: committed zero loses its sign
        add(1, NEG,  0, 0, 9'h000, 9'h100, 0, 0);
        add(1, 4'h0, 0, 0, 9'h000, 9'h100, 1, 0);
        add(1, ENT,  0, 1, 9'h000, 9'h100, 1, 0);
        add(0, 4'h0, 1, 0, 9'h000, 9'h000, 0, 0);
        // 3,8,9: third digit rejected with a single error pulse
        add(1, 4'h3, 0, 0, 9'h000, 9'h003, 1, 0);
        add(1, 4'h8, 0, 0, 9'h000, 9'h038, 2, 0);
        add(1, 4'h9, 0, 0, 9'h000, 9'h038, 2, 1);
        add(0, 4'h0, 0, 0, 9'h000, 9'h038, 2, 0);
        add(1, CLR,  0, 0, 9'h000, 9'h000, 0, 0);
        // 6,1,BSP,BSP,NEG,BSP
        add(1, 4'h6, 0, 0, 9'h000, 9'h006, 1, 0);
        add(1, 4'h1, 0, 0, 9'h000, 9'h061, 2, 0);
        add(1, BSP,  0, 0, 9'h000, 9'h006, 1, 0);
        add(1, BSP,  0, 0, 9'h000, 9'h000, 0, 0);
        add(1, NEG,  0, 0, 9'h000, 9'h100, 0, 0);
        add(1, BSP,  0, 0, 9'h000, 9'h000, 0, 0);
        // IDLE ignores ENT and code E; a digit starts a fresh entry
        add(1, ENT,  0, 0, 9'h000, 9'h000, 0, 0);
        add(1, 4'hE, 0, 0, 9'h000, 9'h000, 0, 0);
        add(1, 4'h1, 0, 0, 9'h000, 9'h001, 1, 0);
        add(1, 4'h2, 0, 0, 9'h000, 9'h012, 2, 0);
        add(1, ENT,  0, 1, 9'h012, 9'h012, 2, 0);
        // key 5 alongside out_ready: transfer wins, key dropped
        add(1, 4'h5, 1, 0, 9'h000, 9'h000, 0, 0);
        add(0, 4'h0, 0, 0, 9'h000, 9'h000, 0, 0);
        // CLR during HOLD aborts without a transfer; other keys are dropped silently
        add(1, 4'h9, 0, 0, 9'h000, 9'h009, 1, 0);
        add(1, ENT,  0, 1, 9'h009, 9'h009, 1, 0);
        add(1, 4'h3, 0, 1, 9'h009, 9'h009, 1, 0);
        add(1, NEG,  0, 1, 9'h009, 9'h009, 1, 0);
        add(1, CLR,  0, 0, 9'h000, 9'h000, 0, 0);
        add(0, 4'h0, 1, 0, 9'h000, 9'h000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].kv, vecs[i].kc, vecs[i].rdy);
            check_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ov,
                      vecs[i].val, vecs[i].disp, vecs[i].cnt, vecs[i].err);
        end

        // asynchronous reset mid-ENTRY
        step(1, NEG, 0);
        step(1, 4'h0, 0);
        step(1, 4'h9, 0);
        check_all("pre_rst_entry", 1'b0, 1'b0, 9'h000, 9'h109, 2'd2, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst_entry", 1'b0, 1'b1, 9'h000, 9'h000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // asynchronous reset mid-HOLD
        step(1, 4'h5, 0);
        step(1, ENT, 0);
        check_all("pre_rst_hold", 1'b1, 1'b1, 9'h005, 9'h005, 2'd1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst_hold", 1'b0, 1'b1, 9'h000, 9'h000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 4'h0, 0);
        check_all("post_rst", 1'b0, 1'b1, 9'h000, 9'h000, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
